// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame width and baud divider helper.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } uart_state_e;

  function automatic int unsigned uart_div(input int unsigned clk_hz,
                                           input int unsigned sclk_hz);
    return clk_hz / sclk_hz;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs.
module sync_2ff #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 with mid-bit sampling and a valid/ready output register.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_error port.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 710000000,
  parameter int unsigned SCLK_HZ = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       framing_error,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       overrun
);

  localparam int unsigned DIV   = uart_div(CLK_HZ, SCLK_HZ);
  localparam int unsigned CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);

  if (DIV < 4) begin : g_div_check
    $error("uart_rx: CLK_HZ/SCLK_HZ must be at least 4");
  end

  logic rxs;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (uart_rxd),
    .q    (rxs)
  );

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [7:0]           data_d;
  logic                 valid_d, fe_d, ov_d;
  logic                 cnt_zero;
`ifdef UART_RX_PARITY_EN
  logic                 par_bad_q, par_bad_d, pe_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shreg_q       <= '0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_error  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shreg_q       <= shreg_d;
      rx_data       <= data_d;
      rx_valid      <= valid_d;
      framing_error <= fe_d;
      overrun       <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_error  <= pe_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_zero = (cnt_q == '0);
    cnt_d    = cnt_zero ? cnt_q : cnt_q - 1'b1;
    idx_d    = idx_q;
    shreg_d  = shreg_q;
    data_d   = rx_data;
    valid_d  = rx_valid && !rx_ready;
    fe_d     = 1'b0;
    ov_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_d      = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          cnt_d   = CNT_HALF;
        end
      end
      START: begin
        if (cnt_zero) begin
          if (!rxs) begin
            state_d = DATA;
            cnt_d   = CNT_FULL;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          cnt_d   = CNT_FULL;
          idx_d   = idx_q + 1'b1;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (cnt_zero) begin
          par_bad_d = (^shreg_q) ^ rxs;
          cnt_d     = CNT_FULL;
          state_d   = STOP;
        end
`else
        state_d = IDLE;
`endif
      end
      STOP: begin
        if (cnt_zero) begin
`ifdef UART_RX_PARITY_EN
          pe_d = par_bad_q;
`endif
          if (rxs) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            if (!par_bad_q) begin
`else
            begin
`endif
              // A handshake in this same cycle frees the register for the new byte.
              if (!rx_valid || rx_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
              end else begin
                ov_d = 1'b1;
              end
            end
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end
      end
      BREAK: begin
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx at DIV=16 (CLK_HZ=16, SCLK_HZ=1).
module tb_uart_rx;

  localparam int unsigned BIT_CYC = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       framing_error;
  logic       overrun;
`ifdef UART_RX_PARITY_EN
  logic       parity_error;
`endif

  uart_rx #(.CLK_HZ(16), .SCLK_HZ(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .uart_rxd     (uart_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .framing_error(framing_error),
`ifdef UART_RX_PARITY_EN
    .parity_error (parity_error),
`endif
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  int       acc_cnt, valid_cycles, fe_cnt, ov_cnt, pe_cnt;
  logic [7:0] last_data;

  always @(negedge clk) begin
    if (rx_valid) valid_cycles++;
    if (rx_valid && rx_ready) begin
      acc_cnt++;
      last_data = rx_data;
    end
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_error) pe_cnt++;
`endif
  end

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_acc;
    int         exp_fe;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    acc_cnt = 0; valid_cycles = 0; fe_cnt = 0; ov_cnt = 0; pe_cnt = 0; last_data = '0;
  endtask

  // Start bit, 8 data bits LSB first, optional even-parity bit (flipped by bad_par), stop bit.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    uart_rxd = 1'b0;
    tick(BIT_CYC);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = d[i];
      tick(BIT_CYC);
    end
`ifdef UART_RX_PARITY_EN
    uart_rxd = (^d) ^ bad_par;
    tick(BIT_CYC);
`else
    if (bad_par) $display("note: parity not built in, bad_par ignored");
`endif
    uart_rxd = stop;
    tick(BIT_CYC);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h55, 1'b0, 0, 1};
    vecs[4] = '{8'h81, 1'b1, 1, 0};

    tick(3);
    check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_errors", {30'd0, framing_error, overrun}, 32'd0);
    reset = 1'b1;
    tick(5);

    for (int v = 0; v < 5; v++) begin
      clear_counts();
      send_frame(vecs[v].data, vecs[v].stop, 1'b0);
      uart_rxd = 1'b1;
      tick(30);
      check($sformatf("vec%0d_accepts", v), acc_cnt, vecs[v].exp_acc);
      check($sformatf("vec%0d_valid_cycles", v), valid_cycles, vecs[v].exp_acc);
      check($sformatf("vec%0d_framing", v), fe_cnt, vecs[v].exp_fe);
      check($sformatf("vec%0d_overrun", v), ov_cnt, 0);
      if (vecs[v].exp_acc != 0)
        check($sformatf("vec%0d_data", v), {24'd0, last_data}, {24'd0, vecs[v].data});
    end

    // Back-to-back frames with the consumer stalled.
    rx_ready = 1'b0;
    clear_counts();
    send_frame(8'h3C, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b0);
    tick(30);
    check("b2b_valid_held", {31'd0, rx_valid}, 32'd1);
    check("b2b_data_held", {24'd0, rx_data}, 32'h3C);
    check("b2b_overrun", ov_cnt, 1);
    check("b2b_framing", fe_cnt, 0);
    rx_ready = 1'b1;
    tick(1);
    check("b2b_valid_cleared", {31'd0, rx_valid}, 32'd0);
    check("b2b_data_kept", {24'd0, rx_data}, 32'h3C);
    check("b2b_accepts", acc_cnt, 1);

    // Short low glitch on an idle line.
    clear_counts();
    uart_rxd = 1'b0;
    tick(4);
    uart_rxd = 1'b1;
    tick(40);
    check("glitch_no_valid", valid_cycles, 0);
    check("glitch_no_error", fe_cnt + ov_cnt, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(30);
    check("glitch_then_accepts", acc_cnt, 1);
    check("glitch_then_data", {24'd0, last_data}, 32'h5A);

    // Bad stop bit followed by a held-low line.
    clear_counts();
    send_frame(8'h55, 1'b0, 1'b0);
    tick(40);
    uart_rxd = 1'b1;
    tick(30);
    check("break_one_framing", fe_cnt, 1);
    check("break_no_valid", valid_cycles, 0);
    clear_counts();
    send_frame(8'h81, 1'b1, 1'b0);
    tick(30);
    check("after_break_accepts", acc_cnt, 1);
    check("after_break_data", {24'd0, last_data}, 32'h81);

    // Reset in the middle of a frame, with a byte still held.
    rx_ready = 1'b0;
    send_frame(8'h99, 1'b1, 1'b0);
    tick(20);
    check("pre_reset_valid", {31'd0, rx_valid}, 32'd1);
    uart_rxd = 1'b0;
    tick(BIT_CYC);
    uart_rxd = 1'b1;
    tick(3 * BIT_CYC);
    reset = 1'b0;
    #2;
    check("async_reset_valid", {31'd0, rx_valid}, 32'd0);
    check("async_reset_data", {24'd0, rx_data}, 32'd0);
    tick(5);
    reset = 1'b1;
    rx_ready = 1'b1;
    clear_counts();
    tick(20);
    check("post_reset_no_partial", valid_cycles, 0);
    send_frame(8'h12, 1'b1, 1'b0);
    tick(30);
    check("post_reset_accepts", acc_cnt, 1);
    check("post_reset_data", {24'd0, last_data}, 32'h12);

`ifdef UART_RX_PARITY_EN
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b0);
    tick(30);
    check("parity_ok_accepts", acc_cnt, 1);
    check("parity_ok_data", {24'd0, last_data}, 32'h07);
    check("parity_ok_no_error", pe_cnt, 0);
    clear_counts();
    send_frame(8'h07, 1'b1, 1'b1);
    tick(30);
    check("parity_bad_pulse", pe_cnt, 1);
    check("parity_bad_no_valid", valid_cycles, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
